a23_shift_operand_stage: RTL
============================

Name: a23_shift_operand_stage

Overview:
Pipeline stage directly upstream of a23_barrel_shift. It decodes the operand-2 field of an ARM data-processing instruction into the barrel shifter's inputs: value, shift amount, function and carry-in. It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the execute stage can stall without losing operands. The block performs no shifting itself.

Parameters:
FIFO_DEPTH, 2, skid-buffer entries; fixed at 2, other values unsupported.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream operand valid
o_ready  output  1  stage can accept an operand this cycle
i_instruction  input  32  data-processing instruction; bits 25, 11:0 used
i_rm_data  input  32  Rm register value
i_rs_data  input  8  Rs[7:0], register shift amount
i_carry_flag  input  1  current CPSR C flag
o_valid  output  1  head entry valid
i_ready  input  1  downstream (barrel shift/ALU) accepts head entry
o_shift_in  output  32  value to shift (barrel i_in)
o_shift_amount  output  8  barrel i_shift_amount
o_shift_function  output  2  LSL=0, LSR=1, ASR=2, ROR=3
o_carry_in  output  1  barrel i_carry_in
o_rrx  output  1  entry is RRX; consumer forces result bit31 = carry_in, carry_out = in[0]

Behaviour:
- Reset (async assert, sync deassert): both entries invalid; o_valid=0; o_ready=1; all data outputs 0.
- Accept when i_valid & o_ready. Decode is combinational on inputs; the decoded entry is written into the buffer.
- Decode, I = instr[25]:
  - I=1: in = {24'b0, instr[7:0]}; function = ROR; amount = {3'b0, instr[11:8], 1'b0}; carry_in = i_carry_flag; rrx = 0.
  - I=0, instr[4]=0 (immediate shift): imm5 = instr[11:7]; type = instr[6:5]; in = i_rm_data; carry_in = i_carry_flag.
    - LSL: amount = imm5.
    - LSR/ASR with imm5 = 0: amount = 8'd32. Otherwise amount = imm5.
    - ROR with imm5 = 0: RRX. function = ROR, amount = 8'd1, rrx = 1. Otherwise ROR by imm5, rrx = 0.
  - I=0, instr[4]=1 (register shift): in = i_rm_data; function = instr[6:5]; amount = i_rs_data, passed unmodified (0 and >=32 handled by the barrel shifter); carry_in = i_carry_flag; rrx = 0.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 (o_valid=1) if the buffer was empty.
- Buffer:
  - FIFO order. Outputs always show the head entry; when o_valid=0, outputs hold their last value.
  - Occupancy rules:
    - Pop when o_valid & i_ready.
    - Push on accept.
    - Simultaneous push and pop: count unchanged, new entry queued behind head.
    - Pop from 1 entry with no push: empty.
  - o_ready = (count < 2), registered (no combinational path from i_ready to o_ready).
    - Full (count=2): i_valid is ignored and no entry is written.
    - A pop while full raises o_ready the next cycle.
- Head entry stable while o_valid & !i_ready (hold).
- Reset mid-operation: all entries discarded immediately; no spurious o_valid after deassert.
- i_carry_flag is sampled at accept, not at pop.

Test Plan:
1. Immediate rotate: instr[25]=1, instr[11:0]=12'h4FF, C=0 -> next cycle o_valid=1, shift_in=0x000000FF, amount=8, function=3, carry_in=0, rrx=0.
2. Immediate-shift specials, Rm=0xDEADBEEF: LSR#0 (instr[6:5]=1, imm5=0) -> amount=32, function=1. ASR#0 -> amount=32, function=2. ROR#0 with C=1 -> function=3, amount=1, rrx=1, carry_in=1. LSL#5 -> amount=5, function=0.
3. Register shift, instr[4]=1, Rs=0x28, ROR, Rm=0x75132312 -> amount=0x28, function=3, in=0x75132312.
4. Backpressure: i_ready=0, push A, B, C back-to-back -> A, B accepted, o_ready=0 after B, C not accepted and held by upstream. Head stays A. Raise i_ready -> outputs A, B, then C in order, no loss or duplication.
5. Streaming: i_valid=1 and i_ready=1 for 31 cycles with distinct operands -> 1 result per cycle, 1-cycle latency, o_ready constantly 1.
6. Reset mid-stream: buffer holds 2 entries, pulse i_rst_n low asynchronously (between clock edges) -> o_valid=0 and o_ready=1 immediately. First post-reset accept appears after 1 cycle.

Source files
------------

// File: rtl/a23_shift_operand_stage_if.sv
// Operand-2 decode stage bus: upstream operand handshake plus the
// downstream barrel-shifter operand handshake.
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low.
interface a23_shift_operand_stage_if;
    // Upstream side
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instruction;
    logic [31:0] i_rm_data;
    logic [7:0]  i_rs_data;
    logic        i_carry_flag;
    // Downstream side
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_shift_in;
    logic [7:0]  o_shift_amount;
    logic [1:0]  o_shift_function;
    logic        o_carry_in;
    logic        o_rrx;

    // Drives operands in and consumes decoded entries
    modport master (
        output i_valid, i_instruction, i_rm_data, i_rs_data, i_carry_flag, i_ready,
        input  o_ready, o_valid, o_shift_in, o_shift_amount, o_shift_function,
        o_carry_in, o_rrx
    );

    // The decode stage itself
    modport slave (
        input  i_valid, i_instruction, i_rm_data, i_rs_data, i_carry_flag, i_ready,
        output o_ready, o_valid, o_shift_in, o_shift_amount, o_shift_function,
        o_carry_in, o_rrx
    );
endinterface

// File: rtl/a23_shift_operand_stage.sv
// Decodes the operand-2 field of an ARM data-processing instruction into
// barrel shifter inputs and queues the result in a 2-entry skid buffer.
// No shifting happens here; 0 and >=32 register amounts pass through to
// the barrel shifter unchanged.
module a23_shift_operand_stage #(
    parameter int FIFO_DEPTH = 2   // fixed at 2; other depths unsupported
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    a23_shift_operand_stage_if.slave     bus
);

    typedef struct packed {
        logic [31:0] shift_in;
        logic [7:0]  amount;
        logic [1:0]  func;
        logic        carry_in;
        logic        rrx;
    } entry_t;

    localparam logic [1:0] SHIFT_LSR = 2'd1;
    localparam logic [1:0] SHIFT_ASR = 2'd2;
    localparam logic [1:0] SHIFT_ROR = 2'd3;

    entry_t     w_dec;
    entry_t     r_head;        // entry 0: always the one on the outputs
    entry_t     r_tail;        // entry 1: only meaningful when r_count == 2
    logic [1:0] r_count;
    logic [1:0] w_count_next;
    logic       r_ready;
    logic       w_push;
    logic       w_pop;
    logic [4:0] w_imm5;
    logic       w_unused_instr;

    // Instruction bits outside the operand-2 field and the I bit are not decoded
    assign w_unused_instr = ^{bus.i_instruction[31:26], bus.i_instruction[24:12]};

    assign w_imm5 = bus.i_instruction[11:7];
    assign w_push = bus.i_valid & r_ready;
    assign w_pop  = (r_count != 2'd0) & bus.i_ready;

    // Operand-2 decode of the incoming instruction
    always_comb begin
        w_dec          = '0;
        w_dec.shift_in = bus.i_rm_data;
        w_dec.carry_in = bus.i_carry_flag;
        w_dec.func     = bus.i_instruction[6:5];
        if (bus.i_instruction[25]) begin
            // 8-bit immediate rotated right by twice the 4-bit rotate field
            w_dec.shift_in = {24'd0, bus.i_instruction[7:0]};
            w_dec.func     = SHIFT_ROR;
            w_dec.amount   = {3'b000, bus.i_instruction[11:8], 1'b0};
        end else if (bus.i_instruction[4]) begin
            // Register-specified shift amount from Rs[7:0]
            w_dec.amount = bus.i_rs_data;
        end else begin
            // Immediate shift; imm5 = 0 encodes the special forms
            w_dec.amount = {3'b000, w_imm5};
            if (w_imm5 == 5'd0) begin
                case (bus.i_instruction[6:5])
                    SHIFT_LSR, SHIFT_ASR: w_dec.amount = 8'd32;
                    SHIFT_ROR: begin
                        // RRX: rotate by one through carry
                        w_dec.amount = 8'd1;
                        w_dec.rrx    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Occupancy and registered ready (ready never depends on i_ready combinationally)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next < 2'(FIFO_DEPTH));
        end
    end

    // Buffer storage; a push can only occur with count < 2, so push+pop means count == 1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push && w_pop) begin
                r_head <= w_dec;
            end else if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head <= r_tail;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= w_dec;
                end else begin
                    r_tail <= w_dec;
                end
            end
        end
    end

    assign bus.o_ready          = r_ready;
    assign bus.o_valid          = (r_count != 2'd0);
    assign bus.o_shift_in       = r_head.shift_in;
    assign bus.o_shift_amount   = r_head.amount;
    assign bus.o_shift_function = r_head.func;
    assign bus.o_carry_in       = r_head.carry_in;
    assign bus.o_rrx            = r_head.rrx;

endmodule
